lzc_norm_pipe: RTL and testbench

- Pipelined leading/trailing-zero counter with a normalising shifter, for FPU mantissa normalisation and priority-select datapaths.
- Each transaction carries its own count direction (mode) and a tag.
- Compute is combinational; results then pass through NUM_STAGES stallable registers under valid/ready flow control.

---
 rtl/lzc_norm_pipe.sv | 106 ++++++++++
 tb/tb_lzc_norm_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// Leading/trailing-zero counter with normalising shift, followed by a
// stallable valid/ready register pipeline of NUM_STAGES stages.
module lzc_norm_pipe #(
    parameter  int WIDTH      = 32,
    parameter  int NUM_STAGES = 2,
    parameter  int TAG_WIDTH  = 4,
    localparam int CNT_WIDTH  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic                 in_mode_i,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o,
    output logic [WIDTH-1:0]     norm_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    localparam int DW = CNT_WIDTH + 1 + WIDTH + TAG_WIDTH;

    logic [CNT_WIDTH-1:0] comp_cnt;
    logic                 comp_empty;
    logic [WIDTH-1:0]     comp_norm;

    genvar gi;

    if (WIDTH == 1) begin : g_w1
        assign comp_cnt   = ~in_data_i;
        assign comp_empty = ~in_data_i[0];
        assign comp_norm  = in_data_i;
    end else begin : g_wn
        logic [CNT_WIDTH-1:0] hi_idx;
        logic [CNT_WIDTH-1:0] lo_idx;

        // Upward scan keeps the highest set bit, downward scan the lowest.
        always_comb begin
            hi_idx = '0;
            lo_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (in_data_i[i]) hi_idx = CNT_WIDTH'(i);
            end
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_data_i[i]) lo_idx = CNT_WIDTH'(i);
            end
        end

        always_comb begin
            comp_empty = ~|in_data_i;
            comp_cnt   = '0;
            comp_norm  = '0;
            if (!comp_empty) begin
                if (!in_mode_i) begin
                    comp_cnt  = CNT_WIDTH'(WIDTH - 1) - hi_idx;
                    comp_norm = in_data_i << comp_cnt;
                end else begin
                    comp_cnt  = lo_idx;
                    comp_norm = in_data_i >> comp_cnt;
                end
            end
        end
    end

    // Index 0 is the combinational result; index k+1 is the register of stage k.
    logic [NUM_STAGES:0] pipe_valid;
    logic [DW-1:0]       pipe_data [0:NUM_STAGES];
    logic [NUM_STAGES:0] ready;

    assign pipe_valid[0]     = in_valid_i;
    assign pipe_data[0]      = {comp_cnt, comp_empty, comp_norm, in_tag_i};
    assign ready[NUM_STAGES] = out_ready_i;

    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic          valid_reg;
        logic [DW-1:0] data_reg;

        // Unrolled ~valid[k] | ready[k+1]: a stage can move unless it and
        // every stage after it is full while the sink is stalled.
        assign ready[gi] = out_ready_i | ~(&pipe_valid[NUM_STAGES:gi+1]);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
            end else if (flush_i) begin
                valid_reg <= 1'b0;
            end else if (ready[gi]) begin
                valid_reg <= pipe_valid[gi];
                data_reg  <= pipe_data[gi];
            end
        end

        assign pipe_valid[gi+1] = valid_reg;
        assign pipe_data[gi+1]  = data_reg;
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = pipe_valid[NUM_STAGES];
    assign {cnt_o, empty_o, norm_o, tag_o} = pipe_data[NUM_STAGES];

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: directed latency/backpressure/flush/reset steps plus
// randomized streaming scored against a shift-and-count reference model.
module tb_lzc_norm_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  cnt;
    logic        empty;
    logic [31:0] norm;
    logic [3:0]  tag;

    logic        w1_in_valid = 1'b0;
    logic        w1_in_ready;
    logic [0:0]  w1_in_data = '0;
    logic [3:0]  w1_in_tag = '0;
    logic        w1_out_valid;
    logic        w1_out_ready = 1'b0;
    logic [0:0]  w1_cnt;
    logic        w1_empty;
    logic [0:0]  w1_norm;
    logic [3:0]  w1_tag;

    always #5 clk = ~clk;

    lzc_norm_pipe #(.WIDTH(32), .NUM_STAGES(2), .TAG_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_mode_i(in_mode), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .cnt_o(cnt), .empty_o(empty), .norm_o(norm), .tag_o(tag)
    );

    lzc_norm_pipe #(.WIDTH(1), .NUM_STAGES(0), .TAG_WIDTH(4)) dut_w1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(w1_in_valid), .in_ready_o(w1_in_ready), .in_data_i(w1_in_data),
        .in_mode_i(1'b0), .in_tag_i(w1_in_tag),
        .out_valid_o(w1_out_valid), .out_ready_i(w1_out_ready),
        .cnt_o(w1_cnt), .empty_o(w1_empty), .norm_o(w1_norm), .tag_o(w1_tag)
    );

    typedef struct packed {
        logic [4:0]  c;
        logic        e;
        logic [31:0] n;
        logic [3:0]  t;
    } res_t;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   out_count = 0;
    int   acc_count = 0;
    logic prev_stall = 1'b0;
    res_t prev_snap;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Shift one bit at a time until the target end holds a one.
    function automatic res_t ref_model(input logic [31:0] d, input logic m, input logic [3:0] t);
        res_t r;
        int c = 0;
        logic [31:0] n = d;
        r.t = t;
        if (d == 32'd0) begin
            r.c = 5'd0; r.e = 1'b1; r.n = 32'd0;
        end else begin
            if (!m) begin
                while (n[31] == 1'b0) begin n = n << 1; c++; end
            end else begin
                while (n[0] == 1'b0) begin n = n >> 1; c++; end
            end
            r.c = 5'(c); r.e = 1'b0; r.n = n;
        end
        return r;
    endfunction

    // One clock: score the output side and record acceptances at the negedge,
    // then return #1 after the rising edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'({cnt, empty, norm, tag}), 64'(prev_snap));
        end
        if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_cnt", 64'(cnt), 64'(e.c));
                chk("out_empty", 64'(empty), 64'(e.e));
                chk("out_norm", 64'(norm), 64'(e.n));
                chk("out_tag", 64'(tag), 64'(e.t));
            end
        end
        prev_stall = out_valid && !out_ready && !flush && !rst;
        prev_snap  = {cnt, empty, norm, tag};
        if (flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(in_data, in_mode, in_tag));
            acc_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [31:0] d, input logic m,
                            input logic [3:0] t, input logic [4:0] ec,
                            input logic ee, input logic [31:0] en);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
        step();
        in_valid = 1'b0;
        chk({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
        step();
        chk({name, "_lat2_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_cnt"}, 64'(cnt), 64'(ec));
        chk({name, "_empty"}, 64'(empty), 64'(ee));
        chk({name, "_norm"}, 64'(norm), 64'(en));
        chk({name, "_tag"}, 64'(tag), 64'(t));
        step();
    endtask

    initial begin
        int start_out;
        int cyc;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({cnt, empty, norm, tag}), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid_after", 64'(out_valid), 64'd0);

        // Directed compute cases
        directed("lz_mid", 32'h0001_0000, 1'b0, 4'd5, 5'd15, 1'b0, 32'h8000_0000);
        directed("tz_mid", 32'h0001_0000, 1'b1, 4'd6, 5'd16, 1'b0, 32'h0000_0001);
        directed("lz_msb", 32'h8000_0000, 1'b0, 4'd7, 5'd0,  1'b0, 32'h8000_0000);
        directed("zero",   32'h0000_0000, 1'b0, 4'd8, 5'd0,  1'b1, 32'h0000_0000);
        directed("tz_zero",32'h0000_0000, 1'b1, 4'd9, 5'd0,  1'b1, 32'h0000_0000);
        directed("tz_msb", 32'h8000_0000, 1'b1, 4'd3, 5'd31, 1'b0, 32'h0000_0001);

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00F0; in_mode = 1'b0; in_tag = 4'd1;
        step();
        in_tag = 4'd2;
        step();
        in_tag = 4'd3;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        step();
        chk("bp_in_ready_held", 64'(in_ready), 64'd0);
        chk("bp_head_tag", 64'(tag), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_order2", 64'(tag), 64'd2);
        step();
        chk("bp_order3", 64'(tag), 64'd3);
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush with two in flight and a third presented
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0300; in_mode = 1'b1; in_tag = 4'd10;
        step();
        in_tag = 4'd11;
        step();
        in_tag = 4'd12; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_out", 64'(out_valid), 64'd0);
        end
        // Flush while the pipe is able to accept
        in_valid = 1'b1; in_tag = 4'd13; flush = 1'b1;
        chk("flush_ready_high", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        step();
        chk("flush_discard", 64'(out_valid), 64'd0);
        directed("post_flush", 32'h0000_4000, 1'b0, 4'd14, 5'd17, 1'b0, 32'h8000_0000);

        // Full-rate streaming
        start_out = out_count;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 31);
            in_mode = 1'($urandom_range(0, 1));
            in_tag = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("full_rate", 64'(out_count - start_out), 64'd18);
        for (int i = 0; i < 4; i++) step();

        // Random streaming with random backpressure
        start_out = acc_count;
        cyc = 0;
        while ((acc_count - start_out) < 100 && cyc < 3000) begin
            if (!in_valid || (in_valid && in_ready)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 31);
                if ($urandom_range(0, 15) == 0) in_data = 32'd0;
                in_mode = 1'($urandom_range(0, 1));
                in_tag = 4'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_accepted", 64'(acc_count - start_out), 64'd100);
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with a full pipe
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0F00_0000; in_mode = 1'b1; in_tag = 4'd15;
        step();
        step();
        in_valid = 1'b0;
        chk("ar_full", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_outputs", 64'({cnt, empty, norm, tag}), 64'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        step();
        #2;
        rst = 1'b0;
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_no_stale", 64'(out_valid), 64'd0);
        end

        // WIDTH=1, NUM_STAGES=0: combinational, ignores reset
        rst = 1'b1;
        w1_in_valid = 1'b1; w1_out_ready = 1'b1; w1_in_data = 1'b0; w1_in_tag = 4'd9;
        #1;
        chk("w1_zero_cnt", 64'(w1_cnt), 64'd1);
        chk("w1_zero_empty", 64'(w1_empty), 64'd1);
        chk("w1_zero_norm", 64'(w1_norm), 64'd0);
        chk("w1_valid", 64'(w1_out_valid), 64'd1);
        chk("w1_tag", 64'(w1_tag), 64'd9);
        w1_in_data = 1'b1;
        #1;
        chk("w1_one", 64'({w1_cnt, w1_empty, w1_norm}), 64'b001);
        w1_in_valid = 1'b0; w1_out_ready = 1'b0;
        #1;
        chk("w1_idle", 64'({w1_out_valid, w1_in_ready}), 64'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
